// File: rtl/inst_size_pkg.sv
// Shared constants and types for the packed instruction-size result unpacker.
// Field table: yy1..yy7 (growing widths) then xx1..xx7 (2 bits each), 42 bits total.
package inst_size_pkg;

   localparam int NUM_FIELDS = 14;
   localparam int PACKED_W   = 42;
   localparam int IN_W       = 128;
   localparam int MAX_FW     = 7;
   localparam int IDX_W      = 4;

   localparam int unsigned FIELD_WIDTH [NUM_FIELDS] =
      '{1, 2, 3, 4, 5, 6, 7, 2, 2, 2, 2, 2, 2, 2};
   localparam int unsigned FIELD_OFFSET [NUM_FIELDS] =
      '{0, 1, 3, 6, 10, 15, 21, 28, 30, 32, 34, 36, 38, 40};

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

endpackage

// File: rtl/inst_size_field_sel.sv
// Combinational field extractor: picks field i_idx out of the packed word, zero-extended.
// Zero latency; no handshake. Indices past the table yield 0.
module inst_size_field_sel
   import inst_size_pkg::*;
#(
   parameter int OUT_W = 8
) (
   input  logic [PACKED_W-1:0] i_word,
   input  logic [IDX_W-1:0]    i_idx,
   output logic [OUT_W-1:0]    o_field
);

   logic [MAX_FW-1:0] w_fields [NUM_FIELDS];

   for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_fld
      assign w_fields[g] = MAX_FW'(i_word[FIELD_OFFSET[g] +: FIELD_WIDTH[g]]);
   end

   always_comb begin
      o_field = '0;
      if (i_idx < IDX_W'(NUM_FIELDS)) begin
         o_field = OUT_W'(w_fields[i_idx]);
      end
   end

endmodule

// File: rtl/inst_size_unpacker.sv
// Captures a 128-bit packed result word and emits its 14 fields one beat at a time.
// First beat the cycle after capture; 15-cycle throughput; out_ready stalls hold all outputs.
module inst_size_unpacker
   import inst_size_pkg::*;
#(
   parameter int OUT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_field,
   output logic [3:0]       out_idx,
   output logic             out_last,
   output logic             out_hi_nz
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FIELDS - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [IN_W-1:0]   r_word;
   logic [IDX_W-1:0]  r_idx;
   logic              w_accept;
   logic              w_xfer;
   logic              w_last;
   logic              w_emit;
   logic [OUT_W-1:0]  w_field;

   assign w_accept = in_valid && in_ready;
   assign w_xfer   = out_valid && out_ready;
   assign w_last   = (r_idx == LAST_IDX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_accept)          w_state_nxt = ST_EMIT;
         ST_EMIT: if (w_xfer && w_last)  w_state_nxt = ST_IDLE;
         default:                        w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_emit    = (r_state == ST_EMIT);
      in_ready  = (r_state == ST_IDLE);
      out_valid = w_emit;
   end

   // Index parks at 0 after the last beat so it can never run past the table.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word <= '0;
         r_idx  <= '0;
      end else if (w_accept) begin
         r_word <= in_data;
         r_idx  <= '0;
      end else if (w_xfer) begin
         r_idx  <= w_last ? '0 : r_idx + 1'b1;
      end
   end

   inst_size_field_sel #(
      .OUT_W (OUT_W)
   ) u_field_sel (
      .i_word  (r_word[PACKED_W-1:0]),
      .i_idx   (r_idx),
      .o_field (w_field)
   );

   always_comb begin
      out_field = w_emit ? w_field : '0;
      out_idx   = w_emit ? r_idx : '0;
      out_last  = w_emit && w_last;
      out_hi_nz = w_emit && w_last && (|r_word[IN_W-1:PACKED_W]);
   end

endmodule
